// File: rtl/processor_pkg.sv
// Shared definitions for the lab processor control unit: opcodes, FSM state codes, ALU selects.
// Pure declarations; no timing or flow control.
package processor_pkg;

   localparam int DEF_RF_ADDR_W = 4;
   localparam int DEF_PC_W      = 7;
   localparam int DEF_D_ADDR_W  = 8;

   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

endpackage

// File: rtl/processor_controller_if.sv
// Control-unit bus: instruction ROM port plus data-memory, ALU and register-file controls.
// Master is the controller; slave is the datapath/memory side. No handshake, strobes are single-cycle.
interface processor_controller_if #(
   parameter int RF_ADDR_W = 4,
   parameter int PC_W      = 7,
   parameter int D_ADDR_W  = 8
);
   logic [15:0]          IM_data;
   logic [PC_W-1:0]      IM_addr;
   logic [D_ADDR_W-1:0]  D_addr;
   logic                 D_wr;
   logic                 RF_s;
   logic [RF_ADDR_W-1:0] RF_W_addr;
   logic                 RF_W_en;
   logic [RF_ADDR_W-1:0] RF_Ra_addr;
   logic [RF_ADDR_W-1:0] RF_Rb_addr;
   logic [2:0]           ALU_s;
   logic                 Halted;
   logic [3:0]           State;

   modport master (
      input  IM_data,
      output IM_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, State
   );

   modport slave (
      output IM_data,
      input  IM_addr, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, ALU_s, Halted, State
   );
endinterface

// File: rtl/program_counter.sv
// Program counter: increments by one when inc is high, wraps silently; async active-low clear.
// Latency: new value visible the cycle after inc; no backpressure.
module program_counter #(
   parameter int PC_W = 7
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic            inc,
   output logic [PC_W-1:0] pc
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pc <= '0;
      end else if (inc) begin
         pc <= pc + PC_W'(1);
      end
   end

endmodule

// File: rtl/processor_controller.sv
// Multi-cycle control unit: fetches from a synchronous ROM, Moore FSM sequences each instruction.
// 3 cycles per instruction (LOAD 4); HALT is terminal until reset; no backpressure.
module processor_controller
   import processor_pkg::*;
#(
   parameter int RF_ADDR_W = DEF_RF_ADDR_W,
   parameter int PC_W      = DEF_PC_W,
   parameter int D_ADDR_W  = DEF_D_ADDR_W
) (
   input  logic                           Clk,
   input  logic                           Reset_n,
   processor_controller_if.master         bus
);

   state_t          state;
   logic [15:0]     ir;
   logic [PC_W-1:0] pc;

   program_counter #(.PC_W(PC_W)) u_pc (
      .clk   (Clk),
      .clr_n (Reset_n),
      .inc   (state == S_FETCH),
      .pc    (pc)
   );

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_INIT;
         ir    <= '0;
      end else begin
         case (state)
            S_INIT:   state <= S_FETCH;
            S_FETCH: begin
               ir    <= bus.IM_data;
               state <= S_DECODE;
            end
            S_DECODE: begin
               // Unassigned opcodes fall through to NOOP.
               case (ir[15:12])
                  OP_STORE: state <= S_STORE;
                  OP_LOAD:  state <= S_LOAD_A;
                  OP_ADD:   state <= S_ADD;
                  OP_SUB:   state <= S_SUB;
                  OP_HALT:  state <= S_HALT;
                  default:  state <= S_NOOP;
               endcase
            end
            S_LOAD_A: state <= S_LOAD_B;
            S_HALT:   state <= S_HALT;
            default:  state <= S_FETCH;
         endcase
      end
   end

   // Moore decode from state and IR; reset forces INIT, so every output drops with Reset_n.
   always_comb begin
      bus.D_addr     = '0;
      bus.D_wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_addr  = '0;
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = '0;
      bus.RF_Rb_addr = '0;
      bus.ALU_s      = ALU_PASS;
      case (state)
         S_LOAD_A: begin
            bus.D_addr = D_ADDR_W'(ir[11:4]);
         end
         S_LOAD_B: begin
            bus.D_addr    = D_ADDR_W'(ir[11:4]);
            bus.RF_s      = 1'b1;
            bus.RF_W_addr = RF_ADDR_W'(ir[3:0]);
            bus.RF_W_en   = 1'b1;
         end
         S_STORE: begin
            bus.D_addr     = D_ADDR_W'(ir[11:4]);
            bus.RF_Ra_addr = RF_ADDR_W'(ir[3:0]);
            bus.D_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            bus.RF_Ra_addr = RF_ADDR_W'(ir[11:8]);
            bus.RF_Rb_addr = RF_ADDR_W'(ir[7:4]);
            bus.RF_W_addr  = RF_ADDR_W'(ir[3:0]);
            bus.RF_W_en    = 1'b1;
            bus.ALU_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
         end
         default: ;
      endcase
   end

   assign bus.IM_addr = pc;
   assign bus.Halted  = (state == S_HALT);
   assign bus.State   = state;

endmodule

// File: tb/tb_processor_controller.sv
// Bench for processor_controller: directed programs plus random ROM images checked cycle by cycle
// against an instruction-level model that expands each instruction into its expected cycles.
module tb_processor_controller;
   import processor_pkg::*;

   typedef struct packed {
      logic [3:0] st;
      logic [6:0] im;
      logic [7:0] da;
      logic       dwr;
      logic       rfs;
      logic [3:0] wa;
      logic       wen;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
      logic       halted;
   } obs_t;

   logic clk;
   logic rst_n;
   logic [15:0] rom [128];
   obs_t exp_q [$];
   int checks;
   int errors;

   processor_controller_if #(.RF_ADDR_W(4), .PC_W(7), .D_ADDR_W(8)) bus ();

   processor_controller #(.RF_ADDR_W(4), .PC_W(7), .D_ADDR_W(8)) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.IM_data <= rom[bus.IM_addr];

   function automatic obs_t sample();
      obs_t o;
      o.st     = bus.State;
      o.im     = bus.IM_addr;
      o.da     = bus.D_addr;
      o.dwr    = bus.D_wr;
      o.rfs    = bus.RF_s;
      o.wa     = bus.RF_W_addr;
      o.wen    = bus.RF_W_en;
      o.ra     = bus.RF_Ra_addr;
      o.rb     = bus.RF_Rb_addr;
      o.alu    = bus.ALU_s;
      o.halted = bus.Halted;
      return o;
   endfunction

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic obs_t idle_rec(logic [3:0] st, int pc);
      obs_t r;
      r    = '0;
      r.st = st;
      r.im = pc[6:0];
      return r;
   endfunction

   // Expand the ROM program into the cycle sequence each instruction should produce.
   task automatic build_model(int ncyc);
      int pc;
      logic [15:0] ins;
      logic [3:0] op;
      obs_t r;
      exp_q.delete();
      exp_q.push_back(idle_rec(S_INIT, 0));
      pc = 0;
      while (exp_q.size() < ncyc) begin
         ins = rom[pc];
         op  = ins[15:12];
         exp_q.push_back(idle_rec(S_FETCH, pc));
         pc = (pc + 1) % 128;
         exp_q.push_back(idle_rec(S_DECODE, pc));
         r = idle_rec(S_NOOP, pc);
         if (op == 4'd1) begin
            r.st = S_STORE; r.da = ins[11:4]; r.ra = ins[3:0]; r.dwr = 1'b1;
            exp_q.push_back(r);
         end else if (op == 4'd2) begin
            r.st = S_LOAD_A; r.da = ins[11:4];
            exp_q.push_back(r);
            r.st = S_LOAD_B; r.rfs = 1'b1; r.wa = ins[3:0]; r.wen = 1'b1;
            exp_q.push_back(r);
         end else if (op == 4'd3 || op == 4'd4) begin
            r.st  = (op == 4'd3) ? S_ADD : S_SUB;
            r.ra  = ins[11:8]; r.rb = ins[7:4]; r.wa = ins[3:0]; r.wen = 1'b1;
            r.alu = (op == 4'd3) ? 3'd1 : 3'd2;
            exp_q.push_back(r);
         end else if (op == 4'd5) begin
            r.st = S_HALT; r.halted = 1'b1;
            while (exp_q.size() < ncyc) exp_q.push_back(r);
         end else begin
            exp_q.push_back(r);
         end
      end
   endtask

   task automatic reset_and_check(string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check($sformatf("%s.reset", tag), 64'(sample()), 64'(idle_rec(S_INIT, 0)));
   endtask

   task automatic run_prog(string tag, int ncyc);
      build_model(ncyc);
      reset_and_check(tag);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check($sformatf("%s[0]", tag), 64'(sample()), 64'(exp_q[0]));
      for (int k = 1; k < ncyc; k++) begin
         @(negedge clk);
         #1;
         check($sformatf("%s[%0d]", tag, k), 64'(sample()), 64'(exp_q[k]));
      end
   endtask

   task automatic fill_rom(logic [15:0] w);
      for (int a = 0; a < 128; a++) rom[a] = w;
   endtask

   initial begin
      logic [3:0] op;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      fill_rom(16'h0000);
      #2;
      check("por", 64'(sample()), 64'(idle_rec(S_INIT, 0)));

      rom[0] = 16'h5000;
      run_prog("halt", 16);
      check("halt.flag", 64'(bus.Halted), 64'd1);
      check("halt.pc", 64'(bus.IM_addr), 64'd1);

      fill_rom(16'h0000);
      rom[0] = 16'h2A53;
      run_prog("load", 8);

      rom[0] = 16'h3127;
      rom[1] = 16'h4127;
      run_prog("addsub", 10);

      fill_rom(16'h0000);
      rom[0] = 16'h11F4;
      run_prog("store", 8);

      fill_rom(16'h0000);
      rom[0] = 16'hF000;
      run_prog("wrap", 1 + 3 * 130);

      // Reset pulse during LOAD_B: the write enable must drop without a clock edge.
      fill_rom(16'h0000);
      rom[0] = 16'h2A53;
      reset_and_check("abort");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) @(negedge clk);
      #1;
      check("abort.wen_before", 64'(bus.RF_W_en), 64'd1);
      check("abort.state_before", 64'(bus.State), 64'(S_LOAD_B));
      #1;
      rst_n = 1'b0;
      #1;
      check("abort.wen_after", 64'(bus.RF_W_en), 64'd0);
      check("abort.rec_after", 64'(sample()), 64'(idle_rec(S_INIT, 0)));
      run_prog("restart", 8);

      for (int it = 0; it < 3; it++) begin
         for (int a = 0; a < 128; a++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd5 && it < 2) op = 4'd3;
            rom[a] = {op, 12'($urandom())};
         end
         run_prog($sformatf("rand%0d", it), 300);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/processor_controller.md
# processor_controller

Multi-cycle control unit for the lab processor. It fetches 16-bit instructions from a synchronous instruction ROM and holds the program counter and instruction register. A Moore state machine sequences each instruction and drives the data-memory, ALU and register-file controls. Its `RF_W_addr`/`RF_W_en` outputs feed the register file's write decoder directly, one stage upstream of it.

## Interface
- `RF_ADDR_W`, default 4: register-file address width; matches the write decoder's `N`, giving 16 registers.
- `PC_W`, default 7: program counter and instruction-ROM address width.
- `D_ADDR_W`, default 8: data-memory address width.
- `Clk` in 1: single clock; all state changes on the rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `IM_data` in 16: instruction ROM read data; synchronous ROM, data valid one cycle after `IM_addr` changes.
- `IM_addr` out `PC_W`: equals PC.
- `D_addr` out `D_ADDR_W`: data-memory address.
- `D_wr` out 1: data-memory write strobe.
- `RF_s` out 1: register-file write mux select; 1 = data memory, 0 = ALU.
- `RF_W_addr` out `RF_ADDR_W`: register-file write address.
- `RF_W_en` out 1: register-file write enable.
- `RF_Ra_addr` out `RF_ADDR_W`: register-file read port A address.
- `RF_Rb_addr` out `RF_ADDR_W`: register-file read port B address.
- `ALU_s` out 3: ALU function select; 0 = pass A, 1 = A+B, 2 = A−B.
- `Halted` out 1: high while in HALT.
- `State` out 4: current state encoding, for debug.

## Operation
- Instruction formats:
  - NOOP = {4'h0, 12'hx}
  - STORE = {4'h1, addr[7:0], Ra[3:0]}: D[addr] ← RF[Ra]
  - LOAD = {4'h2, addr[7:0], Rq[3:0]}: RF[Rq] ← D[addr]
  - ADD = {4'h3, Ra, Rb, Rq}: RF[Rq] ← RF[Ra] + RF[Rb]
  - SUB = {4'h4, Ra, Rb, Rq}: RF[Rq] ← RF[Ra] − RF[Rb]
  - HALT = {4'h5, 12'hx}
  - Opcodes 6–F execute as NOOP.
- States: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Transitions:
  - INIT→FETCH.
  - FETCH→DECODE.
  - DECODE→NOOP / LOAD_A / STORE / ADD / SUB / HALT by `IR[15:12]`.
  - LOAD_A→LOAD_B.
  - LOAD_B, STORE, ADD, SUB, NOOP → FETCH.
  - HALT→HALT until reset.
- FETCH: IR ← `IM_data` and PC ← PC+1 on the exiting edge.
- PC wraps from 2^PC_W−1 to 0 with no flag.
- Outputs are decoded combinationally from state and IR (Moore). In every state not listed below: all strobes 0, `ALU_s`=0, addresses 0.
  - LOAD_A: `D_addr`=`IR[11:4]`.
  - LOAD_B: `D_addr`=`IR[11:4]`, `RF_s`=1, `RF_W_addr`=`IR[3:0]`, `RF_W_en`=1.
  - STORE: `D_addr`=`IR[11:4]`, `RF_Ra_addr`=`IR[3:0]`, `D_wr`=1.
  - ADD/SUB: `RF_Ra_addr`=`IR[11:8]`, `RF_Rb_addr`=`IR[7:4]`, `RF_W_addr`=`IR[3:0]`, `RF_W_en`=1, `RF_s`=0, `ALU_s`=1 (ADD) or 2 (SUB).
- `RF_W_en` is high for exactly one cycle per LOAD/ADD/SUB and never otherwise. The write decoder therefore sees at most one enabled address per cycle.

## Timing
- Reset (`Reset_n`=0) takes effect immediately, with no clock needed:
  - state=INIT, PC=0, IR=16'h0000.
  - Every output is 0: `IM_addr`=0, `D_wr`=0, `RF_W_en`=0, `Halted`=0, `State`=INIT.
- Reset asserted mid-instruction aborts it. A write strobe drops asynchronously with reset.
- The first FETCH follows the first rising edge after release.
- Cycles per instruction: NOOP/STORE/ADD/SUB/HALT-entry = 3 (FETCH, DECODE, EXEC); LOAD = 4.
- `IM_addr` is stable for the whole cycle preceding FETCH, so `IM_data` is valid during FETCH.
- LOAD_A presents `D_addr`; synchronous data memory returns data during LOAD_B, where it is written.
- STORE write occurs on the edge ending STORE.
- In HALT, PC and IR are frozen and `Halted`=1 from the first HALT cycle.

## Structure
- Shared package `processor_pkg`: opcode constants, state encodings (4-bit), ALU select codes, default widths.
- One sub-module: `program_counter` (async active-low clear, increment enable, `PC_W` wide).
- IR register and FSM stay in this module.

## Test plan
- Reset release with ROM[0]=16'h5000 → FETCH, DECODE, then HALT on 3rd cycle; `Halted`=1; PC=1 and stays at 1 for 10+ cycles.
- ROM[0]=16'h2A53 (LOAD) → LOAD_A with `D_addr`=8'hA5; next cycle `RF_W_en`=1, `RF_W_addr`=3, `RF_s`=1, for exactly one cycle; PC=1 after 4 cycles.
- ROM[0]=16'h3127 (ADD) → one cycle with Ra=1, Rb=2, `RF_W_addr`=7, `ALU_s`=1, `RF_W_en`=1; ROM[1]=16'h4127 gives the same with `ALU_s`=2.
- ROM[0]=16'h11F4 (STORE) → `D_addr`=8'h1F, `RF_Ra_addr`=4, `D_wr`=1 for one cycle, `RF_W_en`=0 throughout.
- Opcode 16'hF000 then NOOP-filled ROM of 128 words → no strobes; PC wraps 127→0.
- `Reset_n` pulsed low during LOAD_B → `RF_W_en` falls without a clock edge; state INIT, PC=0; restart refetches ROM[0].
